// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - 12-key synchroniser/debouncer with lowest-key encoder
// Optional KEY_MONO_EN: keys output becomes one-hot of the lowest debounced key.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] raw_keys,
   output logic [11:0] keys,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_event
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [11:0]      sync1;
   logic [11:0]      sync2;
   logic [11:0]      deb;
   logic [11:0]      deb_nxt;
   logic [11:0]      keys_nxt;
   logic [CNT_W-1:0] cnt     [12];
   logic [CNT_W-1:0] cnt_nxt [12];

   // A key flips only after CNT_MAX+1 consecutive disagreeing samples; any agreement restarts it.
   always_comb begin
      deb_nxt = deb;
      for (int i = 0; i < 12; i++) begin
         cnt_nxt[i] = '0;
         if (sync2[i] != deb[i]) begin
            if (cnt[i] == CNT_MAX)
               deb_nxt[i] = sync2[i];
            else
               cnt_nxt[i] = cnt[i] + 1'b1;
         end
      end
   end

`ifdef KEY_MONO_EN
   assign keys_nxt = deb_nxt & (~deb_nxt + 12'd1);
`else
   assign keys_nxt = deb_nxt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= '0;
         sync2     <= '0;
         deb       <= '0;
         keys      <= '0;
         key_event <= 1'b0;
         for (int i = 0; i < 12; i++)
            cnt[i] <= '0;
      end else begin
         sync1     <= raw_keys;
         sync2     <= sync1;
         deb       <= deb_nxt;
         keys      <= keys_nxt;
         key_event <= (keys_nxt != keys);
         for (int i = 0; i < 12; i++)
            cnt[i] <= cnt_nxt[i];
      end
   end

   assign key_valid = |keys;

   always_comb begin
      key_code = 4'd0;
      for (int i = 11; i >= 0; i--)
         if (keys[i])
            key_code = 4'(i);
   end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - scoreboard bench for key_debouncer (DEBOUNCE_CYCLES = 4)
module tb_key_debouncer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] raw_keys;
   logic [11:0] keys;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_event;

   key_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_keys  (raw_keys),
      .keys      (keys),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_event (key_event)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [11:0] k;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int low_idx(logic [11:0] k);
      int r = 0;
      for (int i = 11; i >= 0; i--)
         if (k[i]) r = i;
      return r;
   endfunction

   task automatic chk(string tag, int obs, int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Called right after driving at a falling edge: the change lands 6 rising edges later.
   task automatic expect6(logic [11:0] k);
      exp_t e;
      e.cyc = cyc + 6;
      e.k   = k;
      q.push_back(e);
   endtask

   task automatic drive(logic [11:0] v);
      @(negedge clk);
      raw_keys = v;
   endtask

   task automatic drain(string tag);
      for (int i = 0; i < 20 && q.size() != 0; i++)
         @(negedge clk);
      repeat (8) @(negedge clk);
      chk({"drain_", tag}, q.size(), 0);
   endtask

   // Every key_event pulse must match the next scoreboard entry, on the exact cycle.
   always @(negedge clk) begin
      if (rst_n && key_event) begin
         if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("evt_keys", int'(keys), int'(mon_e.k));
            chk("evt_code", int'(key_code), low_idx(mon_e.k));
            chk("evt_valid", int'(key_valid), int'(mon_e.k != 12'd0));
         end else begin
            mon_e.cyc = -1;
         end
         chk("evt_cycle", cyc, mon_e.cyc);
      end
   end

   initial begin
      rst_n    = 1'b0;
      raw_keys = 12'hFFF;
      repeat (4) @(negedge clk);
      chk("rst_keys", int'(keys), 0);
      chk("rst_valid", int'(key_valid), 0);
      chk("rst_code", int'(key_code), 0);
      chk("rst_event", int'(key_event), 0);
      rst_n = 1'b1;
      expect6(12'hFFF);
      drain("rst_release");
      chk("all_code", int'(key_code), 0);

      drive(12'h000); expect6(12'h000);
      drain("all_release");

      // clean press and release of key 5
      drive(12'h020); expect6(12'h020);
      drain("press5");
      chk("press5_keys", int'(keys), 'h020);
      chk("press5_code", int'(key_code), 5);
      chk("press5_valid", int'(key_valid), 1);
      drive(12'h000); expect6(12'h000);
      drain("release5");

      // bounce on key 2: 3 high / 1 low never qualifies
      for (int k = 0; k < 40; k++)
         drive((k % 4 != 3) ? 12'h004 : 12'h000);
      chk("bounce_keys", int'(keys), 0);
      drive(12'h004); expect6(12'h004);
      drain("bounce_hold");
      chk("bounce_hold_keys", int'(keys), 'h004);
      drive(12'h000); expect6(12'h000);
      drain("bounce_release");

      // simultaneous keys 9 and 4
      drive(12'h210); expect6(12'h210);
      drain("multi");
      chk("multi_code", int'(key_code), 4);
      drive(12'h200); expect6(12'h200);
      drain("multi_drop4");
      chk("multi_drop_code", int'(key_code), 9);
      drive(12'h000); expect6(12'h000);
      drain("multi_release");

      // key 3 held, then key 7 pressed
      drive(12'h008); expect6(12'h008);
      drain("hold3");
      drive(12'h088);
`ifdef KEY_MONO_EN
      drain("press7_masked");
      chk("mono_keys", int'(keys), 'h008);
`else
      expect6(12'h088);
      drain("press7");
      chk("poly_keys", int'(keys), 'h088);
`endif
      chk("hold3_code", int'(key_code), 3);
      drive(12'h080); expect6(12'h080);
      drain("release3");
      chk("release3_code", int'(key_code), 7);
      drive(12'h000); expect6(12'h000);
      drain("release7");

      // reset in the middle of qualifying key 0
      drive(12'h001);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_keys", int'(keys), 0);
      rst_n = 1'b1;
      expect6(12'h001);
      drain("midrst");
      chk("midrst_final", int'(keys), 'h001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
